// File: rtl/traffic_input_latch.sv
// Capture stage between the input synchronizer and the light FSM.
// Turns synchronized levels into a sticky walk request, a debounced
// sensor level and a held reprogram request with a start pulse.
module traffic_input_latch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clk,
  input  logic Reset,
  input  logic Sync_Sensor,
  input  logic Sync_WalkReq,
  input  logic Sync_Reprogram,
  input  logic WR_Reset,
  input  logic Prog_Ack,
  output logic WR,
  output logic Sensor_Stable,
  output logic Prog_Req,
  output logic Prog_Start
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, PENDING} prog_state_t;

  logic [CNT_W-1:0] cnt;
  logic             prev_walk;
  logic             prev_prog;
  logic             walk_rise;
  logic             prog_rise;
  logic             mismatch;
  prog_state_t      state;
  prog_state_t      state_next;
  logic             start_next;

  assign walk_rise = Sync_WalkReq & ~prev_walk;
  assign prog_rise = Sync_Reprogram & ~prev_prog;
  assign mismatch  = Sync_Sensor ^ Sensor_Stable;

  // Edge-detect history for the two button-style inputs
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      prev_walk <= 1'b0;
      prev_prog <= 1'b0;
    end else begin
      prev_walk <= Sync_WalkReq;
      prev_prog <= Sync_Reprogram;
    end
  end

  // Sticky walk request; a new press beats a same-cycle clear so it is never lost
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)          WR <= 1'b0;
    else if (walk_rise) WR <= 1'b1;
    else if (WR_Reset)  WR <= 1'b0;
  end

  // Debounce: count consecutive disagreeing samples, flip after the last one
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      cnt           <= '0;
      Sensor_Stable <= 1'b0;
    end else if (!mismatch) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt           <= '0;
      Sensor_Stable <= ~Sensor_Stable;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Reprogram handshake state and registered start pulse
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      Prog_Start <= 1'b0;
    end else begin
      state      <= state_next;
      Prog_Start <= start_next;
    end
  end

  // Next state: edges while pending are dropped, including one coincident with ack
  always_comb begin
    state_next = state;
    start_next = 1'b0;
    case (state)
      IDLE: if (prog_rise) begin
        state_next = PENDING;
        start_next = 1'b1;
      end
      PENDING: if (Prog_Ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request level is a pure decode of the state register
  always_comb begin
    Prog_Req = (state == PENDING);
  end

endmodule

// File: tb/tb_traffic_input_latch.sv
// Bench for traffic_input_latch: directed table, debounce/reset sequences,
// random stream against a queue-based reference, and a DEBOUNCE_CYCLES=1 copy.
module tb_traffic_input_latch;

  localparam int N = 4;

  logic clk = 1'b0;
  logic Reset;
  logic Sync_Sensor, Sync_WalkReq, Sync_Reprogram, WR_Reset, Prog_Ack;
  logic WR, Sensor_Stable, Prog_Req, Prog_Start;
  logic wr1, ss1, preq1, pstart1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  traffic_input_latch #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
    .clk(clk), .Reset(Reset), .Sync_Sensor(Sync_Sensor), .Sync_WalkReq(Sync_WalkReq),
    .Sync_Reprogram(Sync_Reprogram), .WR_Reset(WR_Reset), .Prog_Ack(Prog_Ack),
    .WR(WR), .Sensor_Stable(Sensor_Stable), .Prog_Req(Prog_Req), .Prog_Start(Prog_Start)
  );

  traffic_input_latch #(.DEBOUNCE_CYCLES(1), .CNT_W(3)) dut1 (
    .clk(clk), .Reset(Reset), .Sync_Sensor(Sync_Sensor), .Sync_WalkReq(Sync_WalkReq),
    .Sync_Reprogram(Sync_Reprogram), .WR_Reset(WR_Reset), .Prog_Ack(Prog_Ack),
    .WR(wr1), .Sensor_Stable(ss1), .Prog_Req(preq1), .Prog_Start(pstart1)
  );

  // Reference model state (spec-level: button edges, pending flag, sample history)
  logic m_prev_walk, m_prev_prog, m_wr, m_pend, m_start, m_stable;
  logic hist[$];

  task automatic model_clear();
    m_prev_walk = 0; m_prev_prog = 0; m_wr = 0; m_pend = 0; m_start = 0; m_stable = 0;
    hist.delete();
  endtask

  task automatic model_step();
    logic wrise, prise, all_diff;
    wrise = Sync_WalkReq && !m_prev_walk;
    prise = Sync_Reprogram && !m_prev_prog;
    if (wrise) m_wr = 1; else if (WR_Reset) m_wr = 0;
    m_start = !m_pend && prise;
    if (m_pend && Prog_Ack) m_pend = 0;
    else if (!m_pend && prise) m_pend = 1;
    hist.push_back(Sync_Sensor);
    if (hist.size() > N) void'(hist.pop_front());
    all_diff = (hist.size() == N);
    foreach (hist[i]) if (hist[i] == m_stable) all_diff = 0;
    if (all_diff) begin
      m_stable = !m_stable;
      hist.delete();
    end
    m_prev_walk = Sync_WalkReq;
    m_prev_prog = Sync_Reprogram;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model sees the same sampled inputs as the DUT, then settle to negedge
  task automatic cycle();
    @(posedge clk);
    if (Reset) model_clear(); else model_step();
    @(negedge clk);
  endtask

  task automatic drive(input logic w, input logic wr_r, input logic s, input logic rp, input logic ack);
    Sync_WalkReq = w; WR_Reset = wr_r; Sync_Sensor = s; Sync_Reprogram = rp; Prog_Ack = ack;
  endtask

  typedef struct {
    logic walk, wr_reset, reprog, ack;
    logic exp_wr, exp_req, exp_start;
  } vec_t;

  vec_t tbl[20];
  logic pat_rise[8];
  logic last_s;

  initial begin
    tbl[0]  = '{1,0,0,0, 1,0,0};  // held through reset -> seen as an edge
    tbl[1]  = '{1,1,0,0, 0,0,0};  // clear
    tbl[2]  = '{1,0,0,0, 0,0,0};  // still held, no re-set
    tbl[3]  = '{0,0,0,0, 0,0,0};
    tbl[4]  = '{1,0,0,0, 1,0,0};  // new press
    tbl[5]  = '{0,0,0,0, 1,0,0};
    tbl[6]  = '{1,1,0,0, 1,0,0};  // press + clear together: set wins
    tbl[7]  = '{0,1,0,0, 0,0,0};
    tbl[8]  = '{0,1,0,0, 0,0,0};  // clear with nothing pending
    tbl[9]  = '{0,0,1,0, 0,1,1};  // reprogram rise
    tbl[10] = '{0,0,1,0, 0,1,0};
    tbl[11] = '{0,0,0,0, 0,1,0};
    tbl[12] = '{0,0,1,0, 0,1,0};  // second rise ignored
    tbl[13] = '{0,0,0,1, 0,0,0};  // ack
    tbl[14] = '{0,0,0,1, 0,0,0};  // ack with nothing pending
    tbl[15] = '{0,0,1,0, 0,1,1};  // third rise -> new start
    tbl[16] = '{0,0,0,0, 0,1,0};
    tbl[17] = '{0,0,1,1, 0,0,0};  // ack + rise coincide: edge consumed
    tbl[18] = '{0,0,1,0, 0,0,0};  // still held, no edge
    tbl[19] = '{0,0,0,0, 0,0,0};
    pat_rise = '{1,1,1,0,1,1,1,1};

    // Reset with walk button held
    Reset = 1;
    drive(1, 0, 0, 0, 0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    chk("reset_wr", WR, 0);
    chk("reset_sensor", Sensor_Stable, 0);
    chk("reset_prog_req", Prog_Req, 0);
    chk("reset_prog_start", Prog_Start, 0);
    Reset = 0;

    // Directed handshake table
    foreach (tbl[i]) begin
      drive(tbl[i].walk, tbl[i].wr_reset, 0, tbl[i].reprog, tbl[i].ack);
      cycle();
      chk($sformatf("tbl%0d_wr", i), WR, tbl[i].exp_wr);
      chk($sformatf("tbl%0d_prog_req", i), Prog_Req, tbl[i].exp_req);
      chk($sformatf("tbl%0d_prog_start", i), Prog_Start, tbl[i].exp_start);
    end

    // Debounce rise: broken run restarts the count, flips only after sample 8
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, pat_rise[i], 0, 0);
      cycle();
      chk($sformatf("deb_rise%0d", i), Sensor_Stable, (i == 7));
    end
    // Mirror fall
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, !pat_rise[i], 0, 0);
      cycle();
      chk($sformatf("deb_fall%0d", i), Sensor_Stable, (i != 7));
    end

    // Build up WR=1, Prog_Req=1, Sensor_Stable=1, then a partial counter
    for (int i = 0; i < N; i++) begin
      drive(0, 0, 1, 0, 0);
      cycle();
    end
    drive(1, 0, 1, 1, 0);
    cycle();
    chk("pre_rst_wr", WR, 1);
    chk("pre_rst_req", Prog_Req, 1);
    chk("pre_rst_sensor", Sensor_Stable, 1);
    drive(0, 0, 0, 0, 0);
    cycle();
    cycle();
    // Asynchronous reset between edges
    #2 Reset = 1;
    #1;
    chk("async_wr", WR, 0);
    chk("async_req", Prog_Req, 0);
    chk("async_sensor", Sensor_Stable, 0);
    chk("async_start", Prog_Start, 0);
    model_clear();
    @(negedge clk);
    Reset = 0;
    // Counter must restart from zero: full N samples needed
    for (int i = 0; i < N; i++) begin
      drive(0, 0, 1, 0, 0);
      cycle();
      chk($sformatf("post_rst_deb%0d", i), Sensor_Stable, (i == N - 1));
    end

    // Random stream against the reference model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
            $urandom_range(0, 1), ($urandom_range(0, 3) == 0));
      cycle();
      chk("rnd_wr", WR, m_wr);
      chk("rnd_sensor", Sensor_Stable, m_stable);
      chk("rnd_prog_req", Prog_Req, m_pend);
      chk("rnd_prog_start", Prog_Start, m_start);
    end

    // DEBOUNCE_CYCLES=1 copy follows the sensor with one cycle delay
    for (int i = 0; i < 50; i++) begin
      last_s = 1'($urandom_range(0, 1));
      drive(0, 0, last_s, 0, 0);
      cycle();
      chk("deb1_follow", ss1, last_s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
